// File: rtl/conv_arbiter.sv
// conv_arbiter: two-requester round-robin front end to a shared
// two's-complement to sign-magnitude converter. The result sits in a
// one-entry output slot behind a valid/ready handshake. A saturating
// counter tracks accepted operands that could not be represented.
module conv_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rsn,
  input  logic             i_req0_valid,
  input  logic [WIDTH-1:0] i_req0_data,
  output logic             o_req0_ready,
  input  logic             i_req1_valid,
  input  logic [WIDTH-1:0] i_req1_data,
  output logic             o_req1_ready,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [WIDTH-1:0] o_res_data,
  output logic             o_res_error,
  output logic             o_res_id,
  output logic [CNT_W-1:0] o_err_cnt,
  input  logic             i_err_clr
);

  localparam int unsigned MAG_W = WIDTH - 1;

  // Output slot states
  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [0:0]       state_q;
  logic [0:0]       state_d;
  logic             prio_q;
  logic             prio_d;

  logic [WIDTH-1:0] res_data_q;
  logic             res_error_q;
  logic             res_id_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic [CNT_W-1:0] err_cnt_d;

  logic             slot_free;
  logic             grant_valid;
  logic             grant_id;
  logic             accept;
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] conv_data;
  logic             conv_error;

  // Two's complement to sign-magnitude; most-negative input is flagged,
  // its magnitude wraps to zero so the result is {1, 0..0}.
  function automatic logic [WIDTH:0] to_sign_mag(input logic [WIDTH-1:0] a);
    logic [MAG_W-1:0] mag;
    logic             err;
    if (a[WIDTH-1]) begin
      mag = MAG_W'(~a[MAG_W-1:0] + MAG_W'(1));
      err = (a[MAG_W-1:0] == '0);
    end else begin
      mag = a[MAG_W-1:0];
      err = 1'b0;
    end
    return {err, a[WIDTH-1], mag};
  endfunction

  // Round-robin grant and slot-free handshake
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    slot_free   = (state_q == S_EMPTY) || i_res_ready;
    if (prio_q == 1'b0) begin
      if (i_req0_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b0;
      end else if (i_req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b1;
      end
    end else begin
      if (i_req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b1;
      end else if (i_req0_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b0;
      end
    end
  end

  // Readies are held low while reset is asserted
  always_comb begin
    o_req0_ready = 1'b0;
    o_req1_ready = 1'b0;
    accept       = 1'b0;
    if (i_rsn && slot_free && grant_valid) begin
      accept       = 1'b1;
      o_req0_ready = (grant_id == 1'b0);
      o_req1_ready = (grant_id == 1'b1);
    end
  end

  // Operand select and conversion of the granted requester
  always_comb begin
    sel_data   = grant_id ? i_req1_data : i_req0_data;
    conv_error = 1'b0;
    conv_data  = '0;
    {conv_error, conv_data} = to_sign_mag(sel_data);
  end

  // Slot state, priority pointer and error counter next values
  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    err_cnt_d = err_cnt_q;
    if (accept) begin
      state_d = S_FULL;
      prio_d  = ~grant_id;
    end else if ((state_q == S_FULL) && i_res_ready) begin
      state_d = S_EMPTY;
    end
    if (i_err_clr) begin
      err_cnt_d = '0;
    end else if (accept && conv_error && (err_cnt_q != CNT_MAX)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  // State, pointer and counter registers
  always_ff @(posedge i_clk or negedge i_rsn) begin
    if (!i_rsn) begin
      state_q   <= S_EMPTY;
      prio_q    <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Result register loads only on acceptance, otherwise holds
  always_ff @(posedge i_clk or negedge i_rsn) begin
    if (!i_rsn) begin
      res_data_q  <= '0;
      res_error_q <= 1'b0;
      res_id_q    <= 1'b0;
    end else if (accept) begin
      res_data_q  <= conv_data;
      res_error_q <= conv_error;
      res_id_q    <= grant_id;
    end
  end

  // Registered outputs
  always_comb begin
    o_res_valid = (state_q == S_FULL);
    o_res_data  = res_data_q;
    o_res_error = res_error_q;
    o_res_id    = res_id_q;
    o_err_cnt   = err_cnt_q;
  end

endmodule

// File: tb/tb_conv_arbiter.sv
// Directed bench for conv_arbiter (WIDTH=32, CNT_W=2).
module tb_conv_arbiter;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 2;

  logic             i_clk;
  logic             i_rsn;
  logic             i_req0_valid;
  logic [WIDTH-1:0] i_req0_data;
  logic             o_req0_ready;
  logic             i_req1_valid;
  logic [WIDTH-1:0] i_req1_data;
  logic             o_req1_ready;
  logic             o_res_valid;
  logic             i_res_ready;
  logic [WIDTH-1:0] o_res_data;
  logic             o_res_error;
  logic             o_res_id;
  logic [CNT_W-1:0] o_err_cnt;
  logic             i_err_clr;

  int vectors;
  int miscompares;

  conv_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .i_clk        (i_clk),
    .i_rsn        (i_rsn),
    .i_req0_valid (i_req0_valid),
    .i_req0_data  (i_req0_data),
    .o_req0_ready (o_req0_ready),
    .i_req1_valid (i_req1_valid),
    .i_req1_data  (i_req1_data),
    .o_req1_ready (o_req1_ready),
    .o_res_valid  (o_res_valid),
    .i_res_ready  (i_res_ready),
    .o_res_data   (o_res_data),
    .o_res_error  (o_res_error),
    .o_res_id     (o_res_id),
    .o_err_cnt    (o_err_cnt),
    .i_err_clr    (i_err_clr)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_res(input string tag, input logic v, input logic [31:0] d,
                         input logic e, input logic id);
    chk({tag, ".valid"}, 64'(o_res_valid), 64'(v));
    chk({tag, ".data"},  64'(o_res_data),  64'(d));
    chk({tag, ".error"}, 64'(o_res_error), 64'(e));
    chk({tag, ".id"},    64'(o_res_id),    64'(id));
  endtask

  task automatic chk_rdy(input string tag, input logic r0, input logic r1);
    chk({tag, ".rdy0"}, 64'(o_req0_ready), 64'(r0));
    chk({tag, ".rdy1"}, 64'(o_req1_ready), 64'(r1));
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    i_rsn        = 1'b0;
    i_req0_valid = 1'b1;
    i_req0_data  = 32'h0000_0005;
    i_req1_valid = 1'b0;
    i_req1_data  = '0;
    i_res_ready  = 1'b1;
    i_err_clr    = 1'b0;

    // Reset state, readies suppressed while reset is low
    #2;
    chk_res("reset", 1'b0, 32'h0, 1'b0, 1'b0);
    chk("reset.cnt", 64'(o_err_cnt), 64'd0);
    chk_rdy("reset", 1'b0, 1'b0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rsn = 1'b1;

    // req0 positive operand, pass-through
    #1;
    chk_rdy("p0", 1'b1, 1'b0);
    tick();
    chk_res("p0", 1'b1, 32'h0000_0005, 1'b0, 1'b0);
    i_req0_valid = 1'b0;

    // req1 only: -1 then most-negative
    i_req1_valid = 1'b1;
    i_req1_data  = 32'hFFFF_FFFF;
    @(negedge i_clk);
    chk_rdy("m1", 1'b0, 1'b1);
    tick();
    chk_res("m1", 1'b1, 32'h8000_0001, 1'b0, 1'b1);
    chk("m1.cnt", 64'(o_err_cnt), 64'd0);
    i_req1_data = 32'h8000_0000;
    tick();
    chk_res("mn", 1'b1, 32'h8000_0000, 1'b1, 1'b1);
    chk("mn.cnt", 64'(o_err_cnt), 64'd1);
    i_req1_valid = 1'b0;
    tick();
    chk_res("drain", 1'b0, 32'h8000_0000, 1'b1, 1'b1);

    // Both valid, consumer ready: grants alternate starting with 0
    i_req0_valid = 1'b1;
    i_req0_data  = 32'h0000_0010;
    i_req1_valid = 1'b1;
    i_req1_data  = 32'h0000_0020;
    for (int i = 0; i < 6; i++) begin
      @(negedge i_clk);
      chk_rdy("rr", (i % 2) == 0, (i % 2) == 1);
      tick();
      chk_res("rr", 1'b1, ((i % 2) == 0) ? 32'h10 : 32'h20, 1'b0, 1'((i % 2) == 1));
    end

    // Consumer stall: slot held, no readies
    i_res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      chk_rdy("stall", 1'b0, 1'b0);
      tick();
      chk_res("stall", 1'b1, 32'h20, 1'b0, 1'b1);
    end
    // Release: consume and accept req0 in the same cycle
    i_res_ready = 1'b1;
    @(negedge i_clk);
    chk_rdy("rel", 1'b1, 1'b0);
    tick();
    chk_res("rel", 1'b1, 32'h10, 1'b0, 1'b0);
    i_req0_valid = 1'b0;
    i_req1_valid = 1'b0;
    tick();
    chk("rel.empty", 64'(o_res_valid), 64'd0);

    // Clear counter, then a non-error negative via req1
    i_err_clr = 1'b1;
    tick();
    chk("clr.cnt", 64'(o_err_cnt), 64'd0);
    i_err_clr    = 1'b0;
    i_req1_valid = 1'b1;
    i_req1_data  = 32'hFFFF_FFFB;
    tick();
    chk_res("m5", 1'b1, 32'h8000_0005, 1'b0, 1'b1);
    chk("m5.cnt", 64'(o_err_cnt), 64'd0);
    i_req1_valid = 1'b0;

    // Five error acceptances: counter saturates at 3
    i_req0_valid = 1'b1;
    i_req0_data  = 32'h8000_0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk(i < 3 ? "sat.cnt" : "sat.hold", 64'(o_err_cnt), (i < 3) ? 64'(i + 1) : 64'd3);
    end
    chk_res("sat", 1'b1, 32'h8000_0000, 1'b1, 1'b0);
    // Clear wins over a concurrent error acceptance
    i_err_clr = 1'b1;
    tick();
    chk("clr6.cnt", 64'(o_err_cnt), 64'd0);
    chk_res("clr6", 1'b1, 32'h8000_0000, 1'b1, 1'b0);
    i_err_clr = 1'b0;

    // One more error so the counter is nonzero, then stall FULL
    tick();
    chk("pre.cnt", 64'(o_err_cnt), 64'd1);
    i_req0_valid = 1'b0;
    i_res_ready  = 1'b0;
    tick();
    chk("pre.full", 64'(o_res_valid), 64'd1);

    // Asynchronous reset mid-cycle while FULL
    #2;
    i_rsn = 1'b0;
    #1;
    chk_res("arst", 1'b0, 32'h0, 1'b0, 1'b0);
    chk("arst.cnt", 64'(o_err_cnt), 64'd0);
    @(negedge i_clk);
    i_rsn        = 1'b1;
    i_res_ready  = 1'b1;
    i_req0_valid = 1'b1;
    i_req0_data  = 32'h0000_0003;
    i_req1_valid = 1'b1;
    i_req1_data  = 32'h0000_0004;
    #1;
    chk_rdy("arst.prio", 1'b1, 1'b0);
    tick();
    chk_res("arst.first", 1'b1, 32'h3, 1'b0, 1'b0);
    i_req0_valid = 1'b0;
    i_req1_valid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
